// File: rtl/alsaqr_rst_seq_if.sv
// alsaqr_rst_seq_if: request/status bundle between the reset sequencer and its environment
// master: drives pll_locked_i, ext_rst_req_i, sw_rst_req_i, wdt_kick_i; observes the reset outputs
// slave : the sequencer; drives dom_rst_no, hyper_reset_no, busy_o, rst_cause_o
interface alsaqr_rst_seq_if #(
  parameter int NumDomains = 3,
  parameter int NumPhys    = 1
);
  logic                  pll_locked_i;
  logic                  ext_rst_req_i;
  logic                  sw_rst_req_i;
  logic                  wdt_kick_i;
  logic [NumDomains-1:0] dom_rst_no;
  logic [NumPhys-1:0]    hyper_reset_no;
  logic                  busy_o;
  logic [2:0]            rst_cause_o;
  modport master (
    output pll_locked_i, ext_rst_req_i, sw_rst_req_i, wdt_kick_i,
    input  dom_rst_no, hyper_reset_no, busy_o, rst_cause_o
  );
  modport slave (
    input  pll_locked_i, ext_rst_req_i, sw_rst_req_i, wdt_kick_i,
    output dom_rst_no, hyper_reset_no, busy_o, rst_cause_o
  );
endinterface

// File: rtl/alsaqr_rst_seq.sv
// alsaqr_rst_seq: lock-qualified, debounced, staged reset sequencer for the AlSaqr FPGA top
// Ports: clk_i (clock-manager clock), rst_ni (async active-low power-on reset),
//        bus (alsaqr_rst_seq_if.slave): lock/pad/software/kick inputs in, staged resets,
//        HyperBus resets, busy flag and last reset cause out.
// Optional watchdog: define ALSAQR_RSTSEQ_WDT_EN.
module alsaqr_rst_seq #(
  parameter int NumDomains     = 3,
  parameter int NumPhys        = 1,
  parameter int DebounceCycles = 16,
  parameter int HyperRstCycles = 200,
  parameter int StageDelay     = 64,
  parameter int WdtCycles      = 2**20
) (
  input logic            clk_i,
  input logic            rst_ni,
  alsaqr_rst_seq_if.slave bus
);
  typedef enum logic [1:0] {HOLD, HYPER, RELEASE, RUN} state_e;
  localparam int CntMax = HyperRstCycles > StageDelay ? HyperRstCycles : StageDelay;
  localparam int CW     = $clog2(CntMax + 1);
  localparam int DW     = $clog2(DebounceCycles + 1);
  localparam int IW     = NumDomains > 1 ? $clog2(NumDomains) : 1;
  state_e                state_q, state_d;
  logic [1:0]            lock_sync_q, ext_sync_q;
  logic                  lock_s, ext_s;
  logic [DW-1:0]         db_cnt_q, db_cnt_d;
  logic                  ext_db_q, ext_db_d, db_hit;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NumDomains-1:0] dom_q, dom_d;
  logic [NumPhys-1:0]    hyper_q, hyper_d;
  logic                  busy_q, busy_d;
  logic [2:0]            cause_q, cause_d;
  logic                  wdt_exp, req;
  assign lock_s = lock_sync_q[1];
  assign ext_s  = ext_sync_q[1];
  // the debounced level flips only after DebounceCycles consecutive disagreeing samples
  assign db_hit = (ext_s != ext_db_q) && (db_cnt_q == DW'(DebounceCycles - 1));
  always_comb begin
    db_cnt_d = (ext_s == ext_db_q || db_hit) ? '0 : db_cnt_q + 1'b1;
    ext_db_d = ext_db_q ^ db_hit;
  end
`ifdef ALSAQR_RSTSEQ_WDT_EN
  localparam int WW = $clog2(WdtCycles + 1);
  logic [WW-1:0] wdt_q, wdt_d;
  // counts only in RUN, so every entry to RUN starts from zero; a kick beats expiry
  assign wdt_exp = (state_q == RUN) && !bus.wdt_kick_i && (wdt_q == WW'(WdtCycles - 1));
  always_comb wdt_d = (state_q != RUN || bus.wdt_kick_i) ? '0 : wdt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wdt_q <= '0;
    else wdt_q <= wdt_d;
`else
  logic unused_wdt;
  assign unused_wdt = bus.wdt_kick_i | (WdtCycles == 0);
  assign wdt_exp    = 1'b0;
`endif
  assign req = !lock_s || ext_db_q || bus.sw_rst_req_i || wdt_exp;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    hyper_d = hyper_q;
    busy_d  = busy_q;
    cause_d = cause_q;
    if (state_q != HOLD && req) begin
      // a request takes precedence over any release due on the same edge
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      hyper_d = '0;
      busy_d  = 1'b1;
      cause_d = !lock_s ? 3'd1 : ext_db_q ? 3'd2 : bus.sw_rst_req_i ? 3'd3 : 3'd4;
    end else begin
      case (state_q)
        HOLD: if (lock_s && !ext_db_q) begin
          state_d = HYPER;
          cnt_d   = '0;
        end
        HYPER: if (cnt_q == CW'(HyperRstCycles - 1)) begin
          state_d = RELEASE;
          hyper_d = '1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
        RELEASE: if (cnt_q == CW'(StageDelay - 1)) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IW'(NumDomains - 1)) begin
            state_d = RUN;
            idx_d   = '0;
            busy_d  = 1'b0;
          end
        end else cnt_d = cnt_q + 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      lock_sync_q <= '0;
      ext_sync_q  <= '0;
      db_cnt_q    <= '0;
      ext_db_q    <= 1'b0;
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_q       <= '0;
      hyper_q     <= '0;
      busy_q      <= 1'b1;
      cause_q     <= 3'd0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], bus.pll_locked_i};
      ext_sync_q  <= {ext_sync_q[0], bus.ext_rst_req_i};
      db_cnt_q    <= db_cnt_d;
      ext_db_q    <= ext_db_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_q       <= dom_d;
      hyper_q     <= hyper_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
    end
  assign bus.dom_rst_no     = dom_q;
  assign bus.hyper_reset_no = hyper_q;
  assign bus.busy_o         = busy_q;
  assign bus.rst_cause_o    = cause_q;
endmodule
